// File: rtl/text_overlay_16x2_pkg.sv
// rtl/text_overlay_16x2_pkg.sv - shared geometry, colours and stage-1 record for the 16x2 text overlay
package text_overlay_16x2_pkg;

    localparam int TXT_COLS = 16;
    localparam int TXT_ROWS = 2;
    localparam int GLYPH_W  = 8;
    localparam int GLYPH_H  = 16;
    localparam int SCALE    = 2;

    localparam int WIN_W = TXT_COLS * GLYPH_W * SCALE;
    localparam int WIN_H = TXT_ROWS * GLYPH_H * SCALE;

    localparam logic [11:0] DEF_FG_RGB     = 12'hFFF;
    localparam logic [11:0] DEF_HILITE_RGB = 12'hFF0;

    typedef struct packed {
        logic [2:0] bit_idx;
        logic       win;
        logic       row;
        logic       von;
    } stage1_t;

endpackage

// File: rtl/text_overlay_16x2_hilite_timer.sv
// rtl/text_overlay_16x2_hilite_timer.sv - frame-counted highlight after a difficulty change
module hilite_timer #(
    parameter int HILITE_FRAMES = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_start,
    input  logic difficulty,
    output logic hl_active,
    output logic blink
);

    logic       diff_q;
    logic       armed;
    logic [7:0] hl_cnt;

    // armed masks the first post-reset sample so a non-zero difficulty at release is not a change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            diff_q <= 1'b0;
            armed  <= 1'b0;
            hl_cnt <= 8'd0;
        end else begin
            armed  <= 1'b1;
            diff_q <= difficulty;
            if (armed && (difficulty != diff_q))
                hl_cnt <= 8'(HILITE_FRAMES);
            else if (frame_start && (hl_cnt != 8'd0))
                hl_cnt <= hl_cnt - 8'd1;
        end
    end

    assign hl_active = (hl_cnt != 8'd0);
    assign blink     = hl_cnt[2];

endmodule

// File: rtl/text_overlay_16x2.sv
// rtl/text_overlay_16x2.sv - two-stage text window pipeline between character ROM and font ROM
module text_overlay_16x2
    import text_overlay_16x2_pkg::*;
#(
    parameter int          X0            = 192,
    parameter int          Y0            = 208,
    parameter logic [11:0] FG_RGB        = DEF_FG_RGB,
    parameter logic [11:0] HILITE_RGB    = DEF_HILITE_RGB,
    parameter int          HILITE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_tick,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        difficulty,
    output logic [7:0]  char_xy,
    input  logic [6:0]  char_code,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_row,
    output logic        text_on,
    output logic [11:0] text_rgb,
    output logic        video_on_d
);

    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + WIN_W);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + WIN_H);

    logic       in_win;
    logic [7:0] rel_x;
    logic [5:0] rel_y;
    logic [3:0] col;
    logic       row;
    logic [3:0] glyph_row;
    logic [2:0] bit_idx;
    stage1_t    s1;
    logic       frame_start;
    logic       hl_active;
    logic       blink;
    logic       lit;

    assign in_win = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI) &&
                    ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);

    // only the low bits of the offset matter, so subtract on the truncated coordinate
    assign rel_x     = pixel_x[7:0] - 8'(X0);
    assign rel_y     = pixel_y[5:0] - 6'(Y0);
    assign col       = rel_x[7:4];
    assign row       = rel_y[5];
    assign glyph_row = rel_y[4:1];
    assign bit_idx   = rel_x[3:1];

    assign char_xy = in_win ? {3'b000, row, col} : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            font_addr <= 11'd0;
            s1        <= '0;
        end else if (pixel_tick) begin
            font_addr  <= {char_code, glyph_row};
            s1.bit_idx <= bit_idx;
            s1.win     <= in_win;
            s1.row     <= row;
            s1.von     <= video_on;
        end
    end

    assign lit = s1.win && s1.von && font_row[3'd7 - s1.bit_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            text_on    <= 1'b0;
            text_rgb   <= 12'h000;
            video_on_d <= 1'b0;
        end else if (pixel_tick) begin
            text_on    <= lit;
            video_on_d <= s1.von;
            if (!lit)
                text_rgb <= 12'h000;
            else if (s1.row && hl_active && blink)
                text_rgb <= HILITE_RGB;
            else
                text_rgb <= FG_RGB;
        end
    end

    assign frame_start = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);

    hilite_timer #(
        .HILITE_FRAMES(HILITE_FRAMES)
    ) u_hilite (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .difficulty (difficulty),
        .hl_active  (hl_active),
        .blink      (blink)
    );

endmodule
